// File: rtl/show_ahead_fifo_reader.sv
// Read-side consumer for a show-ahead FIFO: pops into a 2-entry registered
// skid buffer and presents a valid/ready stream; rdreq never depends on out_ready.
module show_ahead_fifo_reader #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_q,
  output logic                   fifo_rdreq,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] words_read
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [WIDTH-1:0]       skid_q, skid_d;
  logic [COUNT_WIDTH-1:0] words_read_q, words_read_d;
  logic                   run_en_q, run_en_d;
  logic                   pop, accept;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      skid_q       <= '0;
      words_read_q <= '0;
      run_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      skid_q       <= skid_d;
      words_read_q <= words_read_d;
      run_en_q     <= run_en_d;
    end
  end

  // run_en holds off popping for one cycle after reset release.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    skid_d       = skid_q;
    run_en_d     = 1'b1;
    words_read_d = pop ? words_read_q + COUNT_WIDTH'(1) : words_read_q;
    case (state_q)
      EMPTY: begin
        if (pop) begin
          out_data_d = fifo_q;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (pop && accept) begin
          out_data_d = fifo_q;
        end else if (pop) begin
          skid_d  = fifo_q;
          state_d = TWO;
        end else if (accept) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (accept) begin
          out_data_d = skid_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    fifo_rdreq = run_en_q & ~fifo_empty & (state_q != TWO);
    out_valid  = (state_q != EMPTY);
    occupancy  = state_q;
    out_data   = out_data_q;
    words_read = words_read_q;
    pop        = fifo_rdreq;
    accept     = out_valid & out_ready;
  end

endmodule

// File: tb/tb_show_ahead_fifo_reader.sv
// Bench for show_ahead_fifo_reader: queue-level model of the FIFO and the
// 2-entry buffer, per-cycle comparison, plus directed literal checks.
module tb_show_ahead_fifo_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_q = '0;
  logic          fifo_rdreq;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    occupancy;
  logic [CW-1:0] words_read;

  show_ahead_fifo_reader #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .words_read (words_read)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [W-1:0]  fifo[$];
  logic [W-1:0]  mq[$];
  bit            run_en_m = 1'b0;
  logic [CW-1:0] wr_m = '0;
  int            acc_cnt = 0;
  bit            m_pop, m_acc;
  logic [W-1:0]  m_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: buffer is a queue of at most two words, head is what must be shown.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      run_en_m = 1'b0;
      wr_m     = '0;
    end else begin
      m_pop = run_en_m && !fifo_empty && (mq.size() < 2);
      m_acc = (mq.size() != 0) && out_ready;
      if (m_acc) begin
        void'(mq.pop_front());
        acc_cnt++;
      end
      if (m_pop) begin
        m_w = fifo.pop_front();
        mq.push_back(m_w);
        wr_m = wr_m + 1'b1;
      end
      run_en_m = 1'b1;
    end
  end

  always @(negedge clock) begin
    #2;
    if (chk_en) begin
      check("rdreq", 32'(fifo_rdreq), 32'(run_en_m && !fifo_empty && (mq.size() < 2)));
      check("valid", 32'(out_valid), 32'(mq.size() != 0));
      check("occupancy", 32'(occupancy), 32'(mq.size()));
      check("words_read", 32'(words_read), 32'(wr_m));
      if (mq.size() != 0) check("data", 32'(out_data), 32'(mq[0]));
    end
  end

  task automatic step(input bit rdy, input bit bubble);
    @(negedge clock);
    out_ready  = rdy;
    fifo_empty = bubble || (fifo.size() == 0);
    if (fifo_empty) fifo_q = W'($urandom);
    else            fifo_q = fifo[0];
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    for (int i = 1; i <= 8; i++) fifo.push_back(W'(i));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_en = 1'b1;

    // Reset release and streaming
    step(1'b1, 1'b0); rst_n = 1'b1;
    #3; check("rel_rdreq", 32'(fifo_rdreq), 32'd0);
    check("rel_words", 32'(words_read), 32'd0);
    step(1'b1, 1'b0); #3;
    check("first_rdreq", 32'(fifo_rdreq), 32'd1);
    check("first_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0); #3;
    check("first_data", 32'(out_data), 32'h1);
    check("first_words", 32'(words_read), 32'd1);
    check("first_occ", 32'(occupancy), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      step(1'b1, 1'b0); #3;
      check("stream_data", 32'(out_data), 32'(k));
      check("stream_occ", 32'(occupancy), 32'd1);
      check("stream_valid", 32'(out_valid), 32'd1);
    end
    check("stream_words", 32'(words_read), 32'd8);
    step(1'b1, 1'b0); #3;
    check("stream_drained", 32'(occupancy), 32'd0);

    // Backpressure
    for (int i = 1; i <= 5; i++) fifo.push_back(W'(16'h10 + i));
    step(1'b0, 1'b0); #3;
    check("bp_rdreq0", 32'(fifo_rdreq), 32'd1);
    step(1'b0, 1'b0); #3;
    check("bp_occ1", 32'(occupancy), 32'd1);
    step(1'b0, 1'b0); #3;
    check("bp_occ2", 32'(occupancy), 32'd2);
    check("bp_rdreq_off", 32'(fifo_rdreq), 32'd0);
    check("bp_words", 32'(words_read), 32'd10);
    step(1'b0, 1'b0); #3;
    check("bp_hold_data", 32'(out_data), 32'h11);
    check("bp_hold_rdreq", 32'(fifo_rdreq), 32'd0);
    step(1'b1, 1'b0); #3;
    check("bp_rel_data", 32'(out_data), 32'h11);
    for (int j = 2; j <= 5; j++) begin
      step(1'b1, 1'b0); #3;
      check("bp_data", 32'(out_data), 32'(16'h10 + j));
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    check("bp_words_end", 32'(words_read), 32'd13);
    step(1'b1, 1'b0); #3;
    check("bp_drained", 32'(occupancy), 32'd0);

    // Random gating over 1000 words
    base = acc_cnt;
    for (int i = 0; i < 1000; i++) fifo.push_back(W'(16'h1000 + i));
    for (int c = 0; c < 20000 && (acc_cnt - base) < 1000; c++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    check("rand_delivered", 32'(acc_cnt - base), 32'd1000);
    step(1'b1, 1'b0); #3;
    check("rand_drained", 32'(occupancy), 32'd0);

    // Counter wrap
    step(1'b1, 1'b0); rst_n = 1'b0;
    fifo.delete();
    for (int i = 1; i <= 17; i++) fifo.push_back(W'(16'h40 + i));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); rst_n = 1'b1;
    step(1'b1, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 1'b0); #3;
      check("wrap_data", 32'(out_data), 32'(16'h40 + k));
      if (k == 15) check("wrap_15", 32'(words_read), 32'd15);
      if (k == 16) check("wrap_0", 32'(words_read), 32'd0);
      if (k == 17) check("wrap_1", 32'(words_read), 32'd1);
    end
    step(1'b1, 1'b0);

    // Async reset while two words are buffered
    for (int i = 1; i <= 3; i++) fifo.push_back(W'(16'h20 + i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); #2;
    check("ar_occ2", 32'(occupancy), 32'd2);
    #1; rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_words", 32'(words_read), 32'd0);
    fifo.delete();
    fifo.push_back(16'hA5);
    step(1'b1, 1'b0); rst_n = 1'b1;
    #3; check("ar_rel_valid", 32'(out_valid), 32'd0);
    check("ar_rel_rdreq", 32'(fifo_rdreq), 32'd0);
    step(1'b1, 1'b0); #3;
    check("ar_pre_valid", 32'(out_valid), 32'd0);
    check("ar_pre_rdreq", 32'(fifo_rdreq), 32'd1);
    step(1'b1, 1'b0); #3;
    check("ar_new_valid", 32'(out_valid), 32'd1);
    check("ar_new_data", 32'(out_data), 32'hA5);
    check("ar_new_words", 32'(words_read), 32'd1);
    step(1'b1, 1'b0); #3;
    check("ar_end_occ", 32'(occupancy), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
